// File: rtl/router_port_table.sv
`default_nettype none
// ============================================================================
//  Module   : router_port_table
//  Purpose  : Port-to-node-address lookup table for the NoC router. Loaded
//             word by word from the daisy-chained 16-bit configuration bus,
//             forwards the bus downstream once full, and serves NREAD
//             independent lookups.
//  Options  : ROUTER_PORT_TABLE_REG_OUT_EN - register each haddr lane
//             (1-cycle lookup latency, lanes reset to 0).
//  Revision : 1.0 - initial release
// ============================================================================
module router_port_table #(
   parameter int NPORTS = 5,
   parameter int WIDTH  = 8,
   parameter int NREAD  = 2,
   // Bits needed to hold NPORTS-1, never less than one.
   localparam int LOG_NPORTS = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [15:0]                   ram_config_in,
   input  logic                          ram_config_in_valid,
   output logic [15:0]                   ram_config_out,
   output logic                          ram_config_out_valid,
   input  logic                          reload,
   output logic                          config_done,
   input  logic [NREAD*LOG_NPORTS-1:0]   port_id,
   output logic [NREAD*WIDTH-1:0]        haddr
);

   localparam int WPE = (WIDTH + 15) / 16;
   localparam int WCW = (WPE > 1) ? $clog2(WPE) : 1;

   localparam logic [WCW-1:0]        c_last_word  = WCW'(WPE - 1);
   localparam logic [LOG_NPORTS-1:0] c_last_entry = LOG_NPORTS'(NPORTS - 1);
   localparam logic [LOG_NPORTS:0]   c_nports     = (LOG_NPORTS + 1)'(NPORTS);

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [WCW-1:0]          r_word_cnt;
   logic [LOG_NPORTS-1:0]   r_entry_cnt;
   logic [WPE*16-1:0]       r_asm;
   logic [WPE*16-1:0]       w_asm_next;
   logic [WIDTH-1:0]        r_table [NPORTS];

   logic w_wr_en;
   logic w_last_word;
   logic w_last_entry;
   logic w_wr_entry;

   // A word is accepted only while loading; a simultaneous reload drops it.
   assign w_wr_en      = (r_state == LOAD) && ram_config_in_valid && !reload;
   assign w_last_word  = (r_word_cnt == c_last_word);
   assign w_last_entry = (r_entry_cnt == c_last_entry);
   assign w_wr_entry   = w_wr_en && w_last_word;

   assign ram_config_out       = ram_config_in;
   assign ram_config_out_valid = ram_config_in_valid && (r_state == DONE);
   assign config_done          = (r_state == DONE);

   // Merge the incoming word into the entry being assembled, low word first.
   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[{r_word_cnt, 4'b0000} +: 16] = ram_config_in;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= LOAD;
      else       r_state <= w_state_next;
   end

   // Next state: finish after the last word of the last entry; reload restarts.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         LOAD: begin
            if (w_wr_entry && w_last_entry) w_state_next = DONE;
         end
         DONE: begin
            if (reload) w_state_next = LOAD;
         end
         default: w_state_next = LOAD;
      endcase
   end

   // Word and entry counters; both wrap to zero when the table completes.
   always_ff @(posedge clock) begin
      if (reset || reload) begin
         r_word_cnt  <= '0;
         r_entry_cnt <= '0;
      end else if (w_wr_en) begin
         if (w_last_word) begin
            r_word_cnt  <= '0;
            r_entry_cnt <= w_last_entry ? '0 : r_entry_cnt + 1'b1;
         end else begin
            r_word_cnt  <= r_word_cnt + 1'b1;
         end
      end
   end

   // Assembly register holds the lower words of a wide entry between beats.
   always_ff @(posedge clock) begin
      if (w_wr_en) r_asm <= w_asm_next;
   end

   // Table storage is intentionally not reset; entries persist across reloads.
   always_ff @(posedge clock) begin
      if (w_wr_entry) r_table[r_entry_cnt] <= w_asm_next[WIDTH-1:0];
   end

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
      logic [LOG_NPORTS-1:0] w_pid;
      logic [WIDTH-1:0]      w_data;

      assign w_pid  = port_id[gi*LOG_NPORTS +: LOG_NPORTS];
      // Indices past the last entry read as zero.
      assign w_data = ({1'b0, w_pid} < c_nports) ? r_table[w_pid] : '0;

`ifdef ROUTER_PORT_TABLE_REG_OUT_EN
      logic [WIDTH-1:0] r_data;

      // Registered lookup lane.
      always_ff @(posedge clock) begin
         if (reset) r_data <= '0;
         else       r_data <= w_data;
      end

      assign haddr[gi*WIDTH +: WIDTH] = r_data;
`else
      assign haddr[gi*WIDTH +: WIDTH] = w_data;
`endif
   end

endmodule
`default_nettype wire

// File: doc/router_port_table.md
# router_port_table

Parametrised router port-to-address lookup table for the network-on-chip router. It supports wide node addresses (up to 64 bits, loaded as multiple 16-bit words), N independent read ports, and in-field reprogramming through a reload command. The block is loaded from the daisy-chained 16-bit RAM configuration bus. It forwards the bus downstream once its own table is full, and serves combinational or registered lookups to the router's route-computation stages.

## Interface
- NPORTS, 5: number of table entries (router ports); LOG_NPORTS = CLogB2(NPORTS-1)
- WIDTH, 8: node address width, 1..64; WPE = (WIDTH+15)/16 config words per entry
- NREAD, 2: number of independent lookup ports
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ram_config_in  in  16  configuration word
- ram_config_in_valid  in  1  word valid
- ram_config_out  out  16  equals ram_config_in (combinational)
- ram_config_out_valid  out  1  ram_config_in_valid gated by config_done
- reload  in  1  single-cycle pulse: restart loading
- config_done  out  1  table fully loaded
- port_id  in  NREAD*LOG_NPORTS  packed lookup indices, read port i at [i*LOG_NPORTS +: LOG_NPORTS]
- haddr  out  NREAD*WIDTH  packed lookup results, read port i at [i*WIDTH +: WIDTH]

## Operation
- States: LOAD (reset state), DONE. config_done = (state == DONE).
- Counters: word_cnt (0..WPE-1) and entry_cnt (0..NPORTS-1). Both clear on reset and on reload.
- LOAD, valid word: the word goes into an assembly register at bits [word_cnt*16 +: 16], low word first.
  - On the last word of an entry (word_cnt == WPE-1), write assembled[WIDTH-1:0] into entry entry_cnt, clear word_cnt, increment entry_cnt.
  - Bits above WIDTH in the last word are ignored.
- After the last word of entry NPORTS-1 is written, go to DONE.
- LOAD: ram_config_out_valid = 0. No words are forwarded.
- DONE: every valid word is forwarded unchanged. The table is not written.
- Reload:
  - In DONE, reload moves the block to LOAD next cycle.
  - In LOAD, reload restarts at entry 0, word 0. Any partially assembled entry is discarded.
  - Table contents are retained and readable until overwritten.
- Reload and valid in the same cycle:
  - In DONE, the word is forwarded, then reload takes effect.
  - In LOAD, reload wins and the word is dropped.
- Lookup: haddr[i] = table[port_id[i]]. Any port_id >= NPORTS returns all zeros.
- Table storage is not reset. Lookups before the first complete load return undefined data.

## Timing
- Reset values:
  - state = LOAD, config_done = 0, ram_config_out_valid = 0.
  - ram_config_out follows ram_config_in.
  - haddr is undefined, or 0 with registered outputs.
- Config latency: config_done rises the cycle after the (NPORTS*WPE)-th accepted word. Invalid cycles inside the stream are permitted and ignored.
- Write-to-read: a written entry is visible on haddr in the cycle after the write edge.
- Lookup latency: 0 cycles (combinational) by default.
- Reset mid-load discards all progress. The counters restart at 0.

## Configuration
- ROUTER_PORT_TABLE_REG_OUT_EN:
  - Defined: each haddr lane is registered, giving 1-cycle lookup latency. The registers reset to 0.
  - Not defined: lookups are purely combinational from the table.

## Test plan
- NPORTS=5, WIDTH=8, NREAD=2: send words 0x11,0x22,0x33,0x44,0x55 (high byte 0xAB), then port_id={3,1} -> haddr={0x44,0x22}, config_done=1 after the 5th word, ram_config_out_valid=0 throughout.
- After the load, send valid word 0x1234 -> ram_config_out=0x1234 and ram_config_out_valid=1 in the same cycle; table unchanged.
- WIDTH=24, NPORTS=3: send pairs (0x5678,0x0012),(0x9ABC,0x00FF),(0x0001,0x0000) -> entry0=0x125678, entry1=0xFF9ABC, entry2=0x000001; config_done after the 6th word.
- Reload in DONE, then new word 0x99 only -> entry0=0x99, entries 1..4 keep their old values, config_done=0; 4 more words -> done again.
- Reset after 2 of 5 words, then 5 fresh words -> the table holds the fresh words; port_id=7 -> haddr=0.
- Reload asserted together with a valid word in LOAD -> the word is dropped and the next word is written to entry 0. Run with ROUTER_PORT_TABLE_REG_OUT_EN -> haddr lags port_id by exactly one cycle.
